hamming_bank_port: RTL
======================

# hamming_bank_port

One port of the banked, Hamming-protected dual-port RAM: the memory-side responder that the testbench port interface drives and monitors. It accepts enable/write-enable/address/data requests, delays writes by `WRITE_LATENCY` and SEC-DED encodes them into one of four banks. Reads are decoded and corrected, returned after `READ_LATENCY`, and flagged with error status. Two instances, one per port, share the bank array in the top-level memory.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: data word width.
- `ADDRESS_DEPTH`, 16: words per bank; total depth is 4*`ADDRESS_DEPTH`.
- `WRITE_LATENCY`, 2: cycles from write request to array commit; legal range 1..8.
- `READ_LATENCY`, 2: cycles from read request to `o_valid`; legal range 1..8.
- `P` (derived): smallest value with 2^P >= `DATA_WIDTH`+P+1.
- `CW` (derived): `DATA_WIDTH`+P+1; equals 13 at defaults.
- `AW` (derived): $clog2(4*`ADDRESS_DEPTH`).

**Ports**
- `i_clka`, input, 1: port clock; all logic is on the rising edge.
- `i_rstn`, input, 1: reset, asynchronous assert, active-low.
- `i_en`, input, 1: request enable.
- `i_we`, input, 1: 1 = write, 0 = read; ignored when `i_en`=0.
- `i_addr`, input, AW: [AW-1:AW-2] selects the bank, the remaining low bits select the word.
- `i_din`, input, DATA_WIDTH: write data.
- `i_inj`, input, 2: error injection on write. 00 = none, 01 = flip codeword bit 3, 10 = flip bits 3 and 5, 11 = none.
- `o_dout`, output, DATA_WIDTH: corrected read data; holds its value between reads.
- `o_valid`, output, 1: one-cycle pulse marking a new `o_dout`.
- `o_sec`, output, 1: single error corrected; qualified by `o_valid`.
- `o_ded`, output, 1: double error detected; qualified by `o_valid`.
- `o_sec_cnt`, output, 8: saturating count of corrected reads.

## Operation

**Codeword layout**
- c[0] is the overall parity: XOR of c[CW-1:1].
- c[1..CW-1] are Hamming positions. Parity bits sit at positions 1, 2, 4, 8, ...; data bits fill the non-power positions in ascending order, LSB first.
- Parity bit at position 2^k is the even parity over all positions with bit k set.
- Injection is applied after encoding, before the array write.

**Write path**
- A request with `i_en`=1 and `i_we`=1 is captured at edge N.
- The codeword passes through WRITE_LATENCY-1 register stages and commits to the array at edge N+WRITE_LATENCY-1.
- A read issued at edge N+WRITE_LATENCY or later returns the new data. An earlier read returns the old data; there is no forwarding.
- Back-to-back writes, one per cycle, are fully pipelined.

**Read path**
- A request with `i_en`=1 and `i_we`=0 registers the array word at edge N.
- Decode is combinational: a syndrome S over positions 1..CW-1, plus the overall parity check Q.
- Decode outcomes:
  - S=0, Q=0: clean.
  - Q=1: single error. Flip position S; S=0 means c[0] itself. Assert `o_sec`.
  - S≠0, Q=0: double error. Assert `o_ded`; `o_dout` carries the uncorrected data bits.
- Results pass through READ_LATENCY-1 further register stages. `o_valid`, `o_sec` and `o_ded` are pipelined alongside the data.
- One read per cycle is fully pipelined.
- `o_sec_cnt` increments at the edge where `o_valid` and `o_sec` are both 1, and saturates at 255.

**Reset**
- Asserting `i_rstn` low immediately clears all pipeline stages, so in-flight reads and writes are dropped.
- Reset values: `o_dout`=0, `o_valid`=0, `o_sec`=0, `o_ded`=0, `o_sec_cnt`=0.
- Array contents are not reset. Reading a never-written word is undefined.
- Reset is released asynchronously; the first request is accepted at the first rising edge after release.

## Timing

- Read at edge N gives `o_valid`=1 during the cycle after edge N+READ_LATENCY-1, i.e. sampled high at edge N+READ_LATENCY.
- Write at edge N is visible to reads issued at edge ≥ N+WRITE_LATENCY.
- Same-edge write and read to one address on this port is impossible, because `i_we` selects one operation.
- Cross-port collisions are resolved at the top level, not in this block.

## Test plan

- **Basic write/read:** write 8'hA5 to address 0x05, then idle 2 cycles, then read 0x05. Expect `o_valid` 2 cycles after the read edge, `o_dout`=A5, `o_sec`=0, `o_ded`=0.
- **Bank and wrap coverage:** write 8'h11, 22, 33, 44 to addresses 0x00, 0x10, 0x20, 0x30, then write 0x3F=8'hFF. Read all five back-to-back; expect data in order with `o_valid` high 5 consecutive cycles.
- **Single-error correction:** write 8'h3C with `i_inj`=01, then read. Expect `o_dout`=3C, `o_sec`=1, `o_sec_cnt`=1. Repeat 300 times; expect `o_sec_cnt`=255.
- **Double-error detection:** write 8'h96 with `i_inj`=10, then read. Expect `o_ded`=1, `o_sec`=0, and `o_sec_cnt` unchanged.
- **Write-latency hazard:** write 8'h5A to 0x07, where 0x07 previously held 8'h01, and read 0x07 on the next edge. Expect 01; a read one cycle later returns 5A.
- **Reset mid-flight:** issue a read, then assert `i_rstn`=0 before `o_valid`. Expect all outputs 0 immediately, no `o_valid` pulse after release, and `o_sec_cnt`=0.

Source files
------------

// File: rtl/hamming_bank_port.sv
// hamming_bank_port: one port of a banked, SEC-DED protected RAM.
// Writes are Hamming-encoded (with optional error injection) and committed to one of
// four banks after WRITE_LATENCY-1 register stages. Reads register the stored codeword,
// decode and correct it combinationally, then pass the result through READ_LATENCY-1
// further stages with valid/sec/ded flags.
//
// Ports:
//   i_clka     clock, all logic on the rising edge
//   i_rstn     asynchronous active-low reset (clears pipelines, not the array)
//   i_en       request enable
//   i_we       1 = write, 0 = read
//   i_addr     [AW-1:AW-2] bank select, low bits word select
//   i_din      write data
//   i_inj      write error injection: 01 flip bit 3, 10 flip bits 3 and 5
//   o_dout     corrected read data, held between reads
//   o_valid    one-cycle pulse marking new o_dout
//   o_sec      single error corrected (qualified by o_valid)
//   o_ded      double error detected (qualified by o_valid)
//   o_sec_cnt  saturating count of corrected reads
module hamming_bank_port #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_DEPTH = 16,
  parameter int unsigned WRITE_LATENCY = 2,
  parameter int unsigned READ_LATENCY  = 2,
  localparam int unsigned AW = $clog2(4 * ADDRESS_DEPTH)
) (
  input  logic                  i_clka,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic [1:0]            i_inj,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_valid,
  output logic                  o_sec,
  output logic                  o_ded,
  output logic [7:0]            o_sec_cnt
);

  // Smallest P with 2^P >= DATA_WIDTH + P + 1.
  function automatic int unsigned calc_p(input int unsigned dw);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < (dw + p + 1)) p++;
    return p;
  endfunction

  localparam int unsigned P  = calc_p(DATA_WIDTH);
  localparam int unsigned CW = DATA_WIDTH + P + 1;
  localparam int unsigned WW = AW - 2;

  typedef logic [CW-1:0] cw_t;

  // Data fills non-power-of-two positions 1..CW-1 in ascending order; parity bit 2^k
  // covers every position with bit k set; c[0] is the overall parity of c[CW-1:1].
  function automatic cw_t encode(input logic [DATA_WIDTH-1:0] d);
    cw_t         c;
    int unsigned j;
    logic        par;
    c = '0;
    j = 0;
    for (int unsigned p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int unsigned k = 0; k < P; k++) begin
      par = 1'b0;
      for (int unsigned p = 1; p < CW; p++) begin
        if (((p >> k) & 1) != 0) par = par ^ c[p];
      end
      c[32'd1 << k] = par;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input cw_t c);
    logic [DATA_WIDTH-1:0] d;
    int unsigned           j;
    d = '0;
    j = 0;
    for (int unsigned p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    end
    return d;
  endfunction

  cw_t mem [4][ADDRESS_DEPTH];

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic          wr_req;
  cw_t           inj_mask;
  cw_t           wr_cw;
  logic          commit_en;
  cw_t           commit_cw;
  logic [AW-1:0] commit_addr;

  assign wr_req = i_en & i_we;

  always_comb begin
    inj_mask = '0;
    case (i_inj)
      2'b01: inj_mask[3] = 1'b1;
      2'b10: begin
        inj_mask[3] = 1'b1;
        inj_mask[5] = 1'b1;
      end
      default: inj_mask = '0;
    endcase
  end

  assign wr_cw = encode(i_din) ^ inj_mask;

  if (WRITE_LATENCY > 1) begin : g_wpipe
    localparam int unsigned WS = WRITE_LATENCY - 1;
    logic          wv_q  [WS];
    cw_t           wcw_q [WS];
    logic [AW-1:0] wad_q [WS];

    always_ff @(posedge i_clka or negedge i_rstn) begin
      if (!i_rstn) begin
        for (int i = 0; i < int'(WS); i++) begin
          wv_q[i]  <= 1'b0;
          wcw_q[i] <= '0;
          wad_q[i] <= '0;
        end
      end else begin
        wv_q[0]  <= wr_req;
        wcw_q[0] <= wr_cw;
        wad_q[0] <= i_addr;
        for (int i = 1; i < int'(WS); i++) begin
          wv_q[i]  <= wv_q[i-1];
          wcw_q[i] <= wcw_q[i-1];
          wad_q[i] <= wad_q[i-1];
        end
      end
    end

    assign commit_en   = wv_q[WS-1];
    assign commit_cw   = wcw_q[WS-1];
    assign commit_addr = wad_q[WS-1];
  end else begin : g_wdirect
    assign commit_en   = wr_req;
    assign commit_cw   = wr_cw;
    assign commit_addr = i_addr;
  end

  // Array has no reset; contents survive i_rstn.
  always_ff @(posedge i_clka) begin
    if (commit_en) mem[commit_addr[AW-1:AW-2]][commit_addr[WW-1:0]] <= commit_cw;
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic                  rd_req;
  logic                  rd_v_q;
  cw_t                   rd_cw_q;
  logic [P-1:0]          syn;
  logic                  q_err;
  cw_t                   fixed_cw;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_sec;
  logic                  dec_ded;

  assign rd_req = i_en & ~i_we;

  // rd_cw_q only loads on a read so the decoded word holds between reads.
  always_ff @(posedge i_clka or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_v_q  <= 1'b0;
      rd_cw_q <= '0;
    end else begin
      rd_v_q <= rd_req;
      if (rd_req) rd_cw_q <= mem[i_addr[AW-1:AW-2]][i_addr[WW-1:0]];
    end
  end

  always_comb begin
    syn = '0;
    for (int unsigned p = 1; p < CW; p++) begin
      if (rd_cw_q[p]) syn = syn ^ P'(p);
    end
    q_err    = ^rd_cw_q;
    fixed_cw = rd_cw_q;
    // Odd overall parity: single error at position syn (syn == 0 means c[0]).
    if (q_err && (32'(syn) < CW)) fixed_cw[syn] = ~fixed_cw[syn];
    dec_data = extract(fixed_cw);
    dec_sec  = q_err;
    dec_ded  = ~q_err & (syn != '0);
  end

  if (READ_LATENCY > 1) begin : g_rpipe
    localparam int unsigned RS = READ_LATENCY - 1;
    logic                  ov_q   [RS];
    logic                  os_q   [RS];
    logic                  od_q   [RS];
    logic [DATA_WIDTH-1:0] odat_q [RS];

    always_ff @(posedge i_clka or negedge i_rstn) begin
      if (!i_rstn) begin
        for (int i = 0; i < int'(RS); i++) begin
          ov_q[i]   <= 1'b0;
          os_q[i]   <= 1'b0;
          od_q[i]   <= 1'b0;
          odat_q[i] <= '0;
        end
      end else begin
        ov_q[0] <= rd_v_q;
        os_q[0] <= rd_v_q & dec_sec;
        od_q[0] <= rd_v_q & dec_ded;
        if (rd_v_q) odat_q[0] <= dec_data;
        for (int i = 1; i < int'(RS); i++) begin
          ov_q[i] <= ov_q[i-1];
          os_q[i] <= os_q[i-1];
          od_q[i] <= od_q[i-1];
          if (ov_q[i-1]) odat_q[i] <= odat_q[i-1];
        end
      end
    end

    assign o_valid = ov_q[RS-1];
    assign o_sec   = os_q[RS-1];
    assign o_ded   = od_q[RS-1];
    assign o_dout  = odat_q[RS-1];
  end else begin : g_rdirect
    assign o_valid = rd_v_q;
    assign o_sec   = rd_v_q & dec_sec;
    assign o_ded   = rd_v_q & dec_ded;
    assign o_dout  = dec_data;
  end

  // ---------------------------------------------------------------------------
  // Corrected-read counter
  // ---------------------------------------------------------------------------
  logic [7:0] sec_cnt_q;

  always_ff @(posedge i_clka or negedge i_rstn) begin
    if (!i_rstn) begin
      sec_cnt_q <= 8'd0;
    end else if (o_valid && o_sec && (sec_cnt_q != 8'hFF)) begin
      sec_cnt_q <= sec_cnt_q + 8'd1;
    end
  end

  assign o_sec_cnt = sec_cnt_q;

endmodule
